// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan_sel channel selector.
package mux_scan_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  typedef logic [0:0] state_t;

  localparam state_t ST_DIRECT = 1'b0;
  localparam state_t ST_SCAN   = 1'b1;

  // Channel index width, never narrower than one bit.
  function automatic int sel_w_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Wrap-around first-set-bit finder: the lowest masked channel at or after start.
module mux_next_ch
  import mux_scan_pkg::*;
#(
  parameter  int NUM_CH = 64,
  localparam int SEL_W  = sel_w_f(NUM_CH)
) (
  input  logic [SEL_W-1:0]  start,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  next_ch,
  output logic              found
);

  always_comb begin : find
    int c;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    c       = 0;
    next_ch = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(start) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!found && mask[c]) begin
        found   = 1'b1;
        next_ch = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N-channel selector with direct and round-robin scan modes.
// Define MUX_SCAN_MASK_EN to add ch_mask, restricting scan to masked channels.
module mux_scan_sel
  import mux_scan_pkg::*;
#(
  parameter  int NUM_CH = 64,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = sel_w_f(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     mode,
  input  logic                     req_valid,
  input  logic [SEL_W-1:0]         req_sel,
  output logic                     req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     sel_err
`ifdef MUX_SCAN_MASK_EN
  ,
  input  logic [NUM_CH-1:0]        ch_mask
`endif
);

  localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(NUM_CH);
  localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(NUM_CH - 1);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q;
  logic [SEL_W-1:0]  scan_idx, scan_next, idx;
  logic              scan_ok, cap, in_range;
  logic [DATA_W-1:0] sel_data;

`ifdef MUX_SCAN_MASK_EN
  mux_next_ch #(
    .NUM_CH (NUM_CH)
  ) u_next_ch (
    .start   (ptr_q),
    .mask    (ch_mask),
    .next_ch (scan_idx),
    .found   (scan_ok)
  );
`else
  assign scan_idx = ptr_q;
  assign scan_ok  = 1'b1;
`endif

  // The pointer always names the next candidate, one past the last channel taken.
  assign scan_next = (scan_idx == CH_LAST) ? '0 : scan_idx + 1'b1;

  assign req_ready = !out_valid || out_ready;
  assign cap       = req_ready && ((state_q == ST_SCAN) ? scan_ok : req_valid);
  assign idx       = (state_q == ST_SCAN) ? scan_idx : req_sel;
  assign in_range  = {1'b0, idx} < CH_LIMIT;
  assign state_d   = (mode_e'(mode) == MODE_SCAN) ? ST_SCAN : ST_DIRECT;

  // Explicit compare per channel so an out-of-range index reads as zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx == SEL_W'(k)) sel_data = in_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DIRECT;
      ptr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state_q <= state_d;
      if (state_q == ST_DIRECT && state_d == ST_SCAN) ptr_q <= '0;
      else if (state_q == ST_SCAN && cap)               ptr_q <= scan_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      sel_err   <= 1'b0;
    end else if (cap) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_ch    <= idx;
      sel_err   <= !in_range;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
- Parametrised N-channel, W-bit-wide registered selector with a valid/ready output stage.
- Successor to the flat 64:1 single-bit combinational mux.
- Two modes:
  - Direct: requester picks a channel per transaction.
  - Scan: block walks all channels round-robin, one sample per accepted output beat.
- Sits between channel-parallel status/data buses and a single serial consumer (monitor, UART formatter, debug capture).

Parameters:
- NUM_CH, 64, number of input channels (2..256, need not be a power of two).
- DATA_W, 8, bits per channel.
- SEL_W, $clog2(NUM_CH), localparam, channel index width (minimum 1).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_CH*DATA_W  flattened channels; channel k = in_data[k*DATA_W +: DATA_W].
- mode  in  1  0 = direct, 1 = scan.
- req_valid  in  1  direct-mode capture request.
- req_sel  in  SEL_W  direct-mode channel index.
- req_ready  out  1  capture slot available.
- out_valid  out  1  output stage holds a sample.
- out_ready  in  1  consumer accepts the sample.
- out_data  out  DATA_W  sampled channel data.
- out_ch  out  SEL_W  index of the sampled channel.
- sel_err  out  1  qualifies the beat: sampled index was >= NUM_CH.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_ch=0, sel_err=0.
  - Scan pointer = 0, FSM = DIRECT.
- req_ready = !out_valid || out_ready (one-entry stage, full throughput).
- FSM states:
  - DIRECT → SCAN when mode=1 sampled at a clock edge; scan pointer cleared to 0 on entry.
  - SCAN → DIRECT when mode=0; pointer frozen.
  - Mode is sampled every cycle. A mode change never drops or corrupts a sample already in the output stage.
- Capture condition: cap = req_ready && (DIRECT ? req_valid : 1).
- On cap, at the next edge:
  - out_data = selected channel, out_ch = index, out_valid = 1.
  - Latency: exactly 1 cycle from accepted request to out_valid.
- Index source:
  - Direct mode: req_sel.
  - Scan mode: pointer. Pointer increments on each cap and wraps from NUM_CH-1 to 0.
- Out-of-range index (only possible when NUM_CH is not a power of two):
  - out_data = 0, out_ch = index, sel_err = 1 for that beat, out_valid = 1.
  - Scan never produces an out-of-range index.
- in_data is sampled only at the capture edge. It need not be held afterwards.
- Drain without refill (out_valid && out_ready && !cap): out_valid → 0 next cycle.
- Simultaneous drain and capture: stage replaced, out_valid stays 1, no bubble.
- Back-pressure (out_valid && !out_ready):
  - Stage, out_ch and sel_err hold stable.
  - Scan pointer holds.
  - Direct request not taken (req_ready=0); requester must hold req_valid/req_sel.
- Reset mid-transaction: stage discarded immediately and asynchronously; no partial beat emitted.

Optional Feature:
- Macro MUX_SCAN_MASK_EN.
- Defined:
  - Adds input ch_mask [NUM_CH].
  - Scan visits only channels whose mask bit is 1: next channel = first set bit after the current pointer, wrapping.
  - On entry to SCAN the first capture is the lowest set bit.
  - ch_mask all-zero: no scan captures, out_valid falls after drain, pointer holds.
  - Mask changes take effect on the next capture.
  - Direct mode unaffected.
- Undefined: no ch_mask port; every channel visited in order.

Decomposition:
- Package mux_scan_pkg holds:
  - typedef enum mode_e {MODE_DIRECT, MODE_SCAN}.
  - FSM state typedef.
  - Helper function for the default SEL_W computation.
- Sub-module mux_next_ch: combinational wrap-around next-set-bit finder (pointer, mask → next index, found flag).
  - Instantiated only under MUX_SCAN_MASK_EN.
  - Otherwise the pointer is a plain wrap counter.

Test Plan:
- Direct, NUM_CH=64, DATA_W=8, channel k = k+0x40, out_ready=1; req_sel=37 for one cycle.
  - Next cycle: out_valid=1, out_data=0x65, out_ch=37, sel_err=0.
  - Cycle after: out_valid=0.
- Scan, out_ready=1, 70 cycles.
  - out_ch runs 0..63 then 0..5 with no gaps; out_data matches each channel.
  - Pointer wraps 63 → 0.
- Back-pressure: scan with out_ready=0 for 5 cycles after the beat with out_ch=10.
  - out_data/out_ch held at channel 10, req_ready=0.
  - On release: next beat out_ch=11, no skipped or duplicated channel.
- NUM_CH=48, direct req_sel=50.
  - out_valid=1, out_data=0, out_ch=50, sel_err=1.
  - Following req_sel=47: sel_err=0, correct data.
- rst_n pulsed low while out_valid=1 and scan pointer=20.
  - Outputs zero asynchronously.
  - After release in scan mode, first beat out_ch=0.
- MUX_SCAN_MASK_EN, ch_mask=64'h8000_0000_0000_0011.
  - Scan sequence out_ch = 0, 4, 63, 0, 4.
  - Mask=0: no further beats.
